// File: rtl/keypad_emulator.sv
// Responding end of a 4x4 column-scan / row-sense keypad: presses one requested key
// for a programmable time, with optional contact bounce on the press and release edges.
module keypad_emulator #(
    parameter int HOLD_CYCLES   = 100000,
    parameter int GAP_CYCLES    = 100000,
    parameter int BOUNCE_EDGES  = 0,
    parameter int BOUNCE_PERIOD = 500,
    parameter int CNT_W         = 24
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic       key_ready,
    input  logic [3:0] col,
    output logic [3:0] row,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {
        IDLE,
        BOUNCE_IN,
        HOLD,
        BOUNCE_OUT,
        GAP
    } state_t;

    localparam bit HAS_BOUNCE = (BOUNCE_EDGES > 0);
    localparam int TOG_W      = (BOUNCE_EDGES > 1) ? $clog2(BOUNCE_EDGES) : 1;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] PER_LAST  = CNT_W'(BOUNCE_PERIOD - 1);
    localparam logic [TOG_W-1:0] TOG_LAST  = TOG_W'(HAS_BOUNCE ? BOUNCE_EDGES - 1 : 0);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [TOG_W-1:0]   tog_q, tog_d;
    logic               contact_q, contact_d;
    logic [3:0]         code_q, code_d;
    logic [3:0]         row_q, row_d;
    logic               done_q, done_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            tog_q     <= '0;
            contact_q <= 1'b0;
            code_q    <= 4'd0;
            row_q     <= 4'b1111;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            tog_q     <= tog_d;
            contact_q <= contact_d;
            code_q    <= code_d;
            row_q     <= row_d;
            done_q    <= done_d;
        end
    end

    // Each bounce phase is BOUNCE_EDGES levels of BOUNCE_PERIOD cycles; the entry level counts as the first edge.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CNT_W'(1);
        tog_d     = tog_q;
        contact_d = contact_q;
        code_d    = code_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                contact_d = 1'b0;
                cnt_d     = '0;
                tog_d     = '0;
                if (key_valid) begin
                    code_d    = key_code;
                    contact_d = 1'b1;
                    state_d   = HAS_BOUNCE ? BOUNCE_IN : HOLD;
                end
            end
            BOUNCE_IN: begin
                if (cnt_q == PER_LAST) begin
                    cnt_d = '0;
                    if (tog_q == TOG_LAST) begin
                        tog_d     = '0;
                        contact_d = 1'b1;
                        state_d   = HOLD;
                    end else begin
                        tog_d     = tog_q + TOG_W'(1);
                        contact_d = ~contact_q;
                    end
                end
            end
            HOLD: begin
                contact_d = 1'b1;
                if (cnt_q == HOLD_LAST) begin
                    cnt_d     = '0;
                    contact_d = 1'b0;
                    state_d   = HAS_BOUNCE ? BOUNCE_OUT : GAP;
                end
            end
            BOUNCE_OUT: begin
                if (cnt_q == PER_LAST) begin
                    cnt_d = '0;
                    if (tog_q == TOG_LAST) begin
                        tog_d     = '0;
                        contact_d = 1'b0;
                        state_d   = GAP;
                    end else begin
                        tog_d     = tog_q + TOG_W'(1);
                        contact_d = ~contact_q;
                    end
                end
            end
            GAP: begin
                contact_d = 1'b0;
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d   = IDLE;
                cnt_d     = '0;
                tog_d     = '0;
                contact_d = 1'b0;
            end
        endcase
    end

    // Only the latched key's column matters; other column bits never affect the rows.
    always_comb begin
        row_d = 4'b1111;
        if (contact_q && !col[code_q[3:2]]) begin
            row_d = ~(4'b0001 << code_q[1:0]);
        end
    end

    assign row       = row_q;
    assign done      = done_q;
    assign key_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);

endmodule

// File: doc/keypad_emulator.md
Name: keypad_emulator

Overview:
- Synthesisable model of the 4x4 matrix keypad, acting as the responding end of the column-scan / row-sense interface.
- Accepts a key code through a valid/ready handshake, then presents that key as "pressed" on the row lines whenever the scanner drives the matching column low.
- Holds the press for a programmable time, then releases it, with optional contact bounce on both edges.
- Used for on-board self-test of the keypad scanner and for maze auto-play, both without a physical keypad.

Parameters:
- HOLD_CYCLES, 100000: clk cycles the key is held steadily pressed. Minimum 1.
- GAP_CYCLES, 100000: clk cycles of guaranteed release after the press, before the next key is accepted. Minimum 1.
- BOUNCE_EDGES, 0: number of contact toggles injected on the press edge and on the release edge. 0 disables bounce.
- BOUNCE_PERIOD, 500: clk cycles between bounce toggles. Minimum 1.
- CNT_W, 24: width of the internal timing counter. Must hold max(HOLD_CYCLES, GAP_CYCLES, BOUNCE_PERIOD).

Ports:
- clk  in  1  system clock, 50 MHz
- reset  in  1  asynchronous, active-high reset
- key_valid  in  1  request to press the key given on key_code
- key_code  in  4  key index 0..15: column index = key_code[3:2], row index = key_code[1:0]
- key_ready  out  1  high when a new request can be accepted
- col  in  4  column drive from the scanner, active-low
- row  out  4  row sense to the scanner, active-low, idle 4'b1111
- busy  out  1  high from acceptance until return to IDLE
- done  out  1  one-cycle pulse when the press/release sequence completes

Behaviour:
- Reset (async, active-high) values: row=4'b1111, key_ready=1, busy=0, done=0, state=IDLE, contact=0, counter=0, latched code=0.
- Reset asserted mid-sequence releases the key immediately: row=4'b1111 with no bounce.
- Key mapping (matches the scanner decode):
  - c = key_code[3:2], r = key_code[1:0].
  - The key connects col[c] to row[r]. Example: key 6 → c=1, r=2; col=4'b1101 gives row=4'b1011.
- Row generation (registered, 1 clk latency from col):
  - If contact=1 and col[c]==0: row = all ones except row[r]=0.
  - Otherwise: row = 4'b1111.
  - Other col bits are ignored, so col=4'b0000 (scanner idle probe) also pulls row[r] low while contact=1.
- Handshake:
  - Transfer occurs when key_valid & key_ready on a rising clk. key_code is latched on that edge.
  - key_ready = (state==IDLE), so it drops the cycle after acceptance.
  - key_code is ignored when no transfer occurs.
- State machine; the counter resets to 0 on every state entry:
  - IDLE: contact=0. On transfer, go to BOUNCE_IN if BOUNCE_EDGES>0, otherwise to HOLD.
  - BOUNCE_IN: contact=1 on entry. contact toggles every BOUNCE_PERIOD cycles. After BOUNCE_EDGES toggles, go to HOLD.
  - HOLD: contact forced to 1 for HOLD_CYCLES cycles. Then go to BOUNCE_OUT if BOUNCE_EDGES>0, otherwise to GAP.
  - BOUNCE_OUT: contact=0 on entry. contact toggles every BOUNCE_PERIOD cycles. After BOUNCE_EDGES toggles, go to GAP.
  - GAP: contact forced to 0 for GAP_CYCLES cycles. Then go to IDLE, with done=1 for exactly that one transition cycle.
- Timing:
  - busy = (state != IDLE).
  - With BOUNCE_EDGES=0, contact is 1 for exactly HOLD_CYCLES cycles.
  - Acceptance to done = HOLD_CYCLES + GAP_CYCLES cycles (+1 edge).
- Back-to-back: key_valid held high is accepted on the first cycle after done, because key_ready rises when state returns to IDLE. No request is lost and none is double-accepted.
- col changes at any time, including during bounce, are reflected on row after 1 clk with no glitch.
- An out-of-range key_code cannot occur: the field is 4 bits, so all 16 values are legal.

Test Plan:
- Reset, then idle with col cycling 0000/1110/1101/1011/0111 → row stays 4'b1111, key_ready=1, busy=0, done=0.
- HOLD=8, GAP=4, BOUNCE_EDGES=0; request key 6; col held at 4'b1101 → row=4'b1011 for exactly 8 cycles starting 1 clk after the contact rises. In the same run: col=4'b1110 → row=4'b1111; col=4'b0000 → row=4'b1011. done pulses once, 12 cycles after acceptance.
- Full system with the keypad scanner, default parameters, keys 0, 5, 10, 15 requested back-to-back → scanner outputs key_value 0, 5, 10, 15 in order, each returning to high-Z between presses. key_ready is never high while busy is high.
- BOUNCE_EDGES=3, BOUNCE_PERIOD=2, col=4'b0111, key 13 → row[1] toggles 0,1,0 at 2-cycle intervals, then holds 0 for HOLD_CYCLES. On release, row[1] toggles 1,0,1, then stays high through GAP.
- Assert reset during HOLD with key 3 pressed, col=4'b1110 → row=4'b1111 immediately (async), busy=0, key_ready=1. After reset release, a new request for key 0 is accepted normally.
- key_valid pulsed during busy (key 9 requested while key 2 in progress) → ignored. Only key 2 is presented, and key_ready stays low until the key 2 sequence completes.
